// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one imem read at a time, buffers
// returned words for decode and handles branch redirects with wrong-path discard.
module instr_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    input  logic              pcsrc,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr,
    output logic [3:0]        cond,
    output logic [1:0]        op,
    output logic [5:0]        funct,
    output logic [3:0]        rd,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [ADDR_W-1:0] instr_pc8
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {FETCH, WAIT, DISCARD} state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [ADDR_W-1:0] req_addr_reg;
    logic [PTR_W-1:0]  head_reg, tail_reg;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic              held_reg;
    logic              run_reg;

    logic [31:0]       data_mem [DEPTH];
    logic [ADDR_W-1:0] addr_mem [DEPTH];

    logic req_ok, grant, push, pop, in_flight;

    // run_reg keeps the request low while reset is asserted and for the release cycle;
    // held_reg keeps an ungranted request alive through stall.
    assign req_ok    = (state_reg == FETCH) && run_reg &&
                       (held_reg || (!stall && (count_reg < CNT_W'(DEPTH))));
    assign grant     = req_ok && imem_gnt;
    assign push      = (state_reg == WAIT) && imem_rvalid && !pcsrc;
    assign pop       = instr_valid && instr_ready && !pcsrc;
    assign in_flight = grant || ((state_reg != FETCH) && !imem_rvalid);
    assign imem_addr = pc_reg;

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        imem_req   = 1'b0;
        case (state_reg)
            FETCH: begin
                imem_req = req_ok;
                if (grant) begin
                    pc_next    = pc_reg + ADDR_W'(4);
                    state_next = WAIT;
                end
            end
            WAIT, DISCARD: begin
                if (imem_rvalid) begin
                    state_next = FETCH;
                end
            end
            default: state_next = FETCH;
        endcase
        // A redirect overrides everything; a read still in flight must be swallowed.
        if (pcsrc) begin
            pc_next    = branch_target & ~ADDR_W'(3);
            state_next = in_flight ? DISCARD : FETCH;
        end
    end

    always_comb begin
        count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
        if (pcsrc) begin
            count_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= FETCH;
            pc_reg       <= RESET_PC;
            req_addr_reg <= '0;
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
            held_reg     <= 1'b0;
            run_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            count_reg <= count_next;
            run_reg   <= 1'b1;
            held_reg  <= imem_req && !imem_gnt && !pcsrc;
            if (grant) begin
                req_addr_reg <= pc_reg;
            end
            if (pcsrc) begin
                head_reg <= '0;
                tail_reg <= '0;
            end else begin
                if (push) begin
                    tail_reg <= tail_reg + PTR_W'(1);
                end
                if (pop) begin
                    head_reg <= head_reg + PTR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[tail_reg] <= imem_rdata;
            addr_mem[tail_reg] <= req_addr_reg;
        end
    end

    assign instr_valid = (count_reg != '0);
    assign instr       = instr_valid ? data_mem[head_reg] : '0;
    assign instr_pc    = instr_valid ? addr_mem[head_reg] : '0;
    assign instr_pc8   = instr_valid ? (addr_mem[head_reg] + ADDR_W'(8)) : '0;
    assign cond        = instr[31:28];
    assign op          = instr[27:26];
    assign funct       = instr[25:20];
    assign rd          = instr[15:12];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus random traffic checked
// against a program-order model of fetch addresses and delivered instructions.
module tb_instr_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n, stall, imem_req, imem_gnt, imem_rvalid, pcsrc;
    logic        instr_valid, instr_ready;
    logic [31:0] imem_addr, imem_rdata, branch_target, instr, instr_pc, instr_pc8;
    logic [3:0]  cond, rd;
    logic [1:0]  op;
    logic [5:0]  funct;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .pcsrc        (pcsrc),
        .branch_target(branch_target),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr        (instr),
        .cond         (cond),
        .op           (op),
        .funct        (funct),
        .rd           (rd),
        .instr_pc     (instr_pc),
        .instr_pc8    (instr_pc8)
    );

    int checks = 0;
    int errors = 0;

    // stimulus knobs applied each cycle
    bit          drv_rst_n = 1'b0, drv_gnt = 1'b0, drv_ready = 1'b0, drv_stall = 1'b0;
    bit          drv_pcsrc = 1'b0, pcsrc_on_rv = 1'b0;
    logic [31:0] drv_target = '0;
    int          mem_lat = 0;

    // memory responder and program-order model
    bit          mem_busy = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = '0;
    logic [31:0] exp_req = '0, exp_pop = '0, last_pop_pc = '0, last_grant_addr = '0;
    int          pops = 0, grants = 0;
    bit          prev_pcsrc = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] memword(input logic [31:0] a);
        if (a == 32'h0) return 32'hE3A01005;
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    task automatic model();
        logic [31:0] exp_w;
        if (!rst_n) begin
            check("rst_req", imem_req, 0);
            check("rst_valid", instr_valid, 0);
            check("rst_addr", imem_addr, 0);
            check("rst_outs", instr | instr_pc | instr_pc8, 0);
            exp_req    = '0;
            exp_pop    = '0;
            prev_pcsrc = 1'b0;
            return;
        end
        if (prev_pcsrc) check("flush_valid", instr_valid, 0);
        if (instr_valid) begin
            exp_w = memword(exp_pop);
            check("head_pc", instr_pc, exp_pop);
            check("head_pc8", instr_pc8, exp_pop + 32'd8);
            check("head_instr", instr, exp_w);
            check("head_fields", {cond, op, funct, rd},
                  {exp_w[31:28], exp_w[27:26], exp_w[25:20], exp_w[15:12]});
        end else begin
            check("empty_outs", instr | instr_pc | instr_pc8 | {16'h0, cond, op, funct, rd}, 0);
        end
        if (imem_req) check("req_addr", imem_addr, exp_req);
        if (imem_req && imem_gnt) begin
            check("one_outstanding", mem_busy, 0);
            mem_busy        = 1'b1;
            mem_addr        = imem_addr;
            mem_cnt         = (mem_lat < 0) ? int'($urandom_range(0, 3)) : mem_lat;
            last_grant_addr = imem_addr;
            exp_req         = exp_req + 32'd4;
            grants++;
        end
        if (instr_valid && instr_ready && !pcsrc) begin
            $display("POP pc=%h instr=%h", instr_pc, instr);
            last_pop_pc = instr_pc;
            exp_pop     = exp_pop + 32'd4;
            pops++;
        end
        if (pcsrc) begin
            exp_req = branch_target & ~32'd3;
            exp_pop = branch_target & ~32'd3;
        end
        prev_pcsrc = pcsrc;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        rst_n         = drv_rst_n;
        imem_gnt      = drv_gnt;
        instr_ready   = drv_ready;
        stall         = drv_stall;
        branch_target = drv_target;
        imem_rvalid   = 1'b0;
        imem_rdata    = '0;
        if (mem_busy) begin
            if (mem_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = memword(mem_addr);
                mem_busy    = 1'b0;
            end else begin
                mem_cnt--;
            end
        end
        pcsrc = drv_pcsrc || (pcsrc_on_rv && imem_rvalid);
        @(negedge clk);
        model();
        drv_pcsrc = 1'b0;
    endtask

    task automatic do_reset(input bit keep_mem);
        drv_rst_n = 1'b0;
        if (!keep_mem) mem_busy = 1'b0;
        cycle();
        cycle();
        drv_rst_n = 1'b1;
    endtask

    task automatic wait_grant(input string tag);
        int g0;
        g0 = grants;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (grants != g0) return;
        end
        check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (instr_valid) return;
        end
        check({tag, "_timeout"}, 0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=%0d exp=%0d", 0, 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p0, g0;
        rst_n = 1'b0; stall = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        pcsrc = 1'b0; branch_target = '0; instr_ready = 1'b0;

        // reset, first-fetch latency, field split, throughput
        do_reset(0);
        drv_gnt = 1; drv_ready = 1; mem_lat = 0;
        for (int k = 1; k <= 3; k++) begin
            cycle();
            check("latency_pre", instr_valid, 0);
        end
        cycle();
        check("latency_valid", instr_valid, 1);
        check("first_pc", instr_pc, 0);
        check("first_pc8", instr_pc8, 8);
        check("first_cond", cond, 4'hE);
        check("first_op", op, 2'h0);
        check("first_funct", funct, 6'h3A);
        check("first_rd", rd, 4'h1);
        p0 = pops;
        repeat (20) cycle();
        check("throughput", ((pops - p0) >= 9) && ((pops - p0) <= 10), 1);

        // buffer full with decode blocked
        do_reset(0);
        drv_ready = 0; drv_gnt = 1; mem_lat = 0;
        g0 = grants;
        repeat (12) cycle();
        check("full_grants", grants - g0, 2);
        check("full_req", imem_req, 0);
        drv_ready = 1;
        p0 = pops;
        cycle();
        check("first_pop_cnt", pops - p0, 1);
        check("first_pop_pc", last_pop_pc, 0);
        cycle();
        check("refill_req", imem_req, 1);
        check("refill_addr", imem_addr, 32'h8);
        check("second_pop_pc", last_pop_pc, 32'h4);

        // redirect while a read is in flight
        do_reset(0);
        drv_ready = 1; drv_gnt = 1; mem_lat = 3;
        wait_grant("wait_first");
        mem_lat = 0; drv_target = 32'h103; drv_pcsrc = 1;
        cycle();
        wait_grant("wait_redirect");
        check("redirect_addr", last_grant_addr, 32'h100);
        wait_valid("redirect_valid");
        check("redirect_head", instr_pc, 32'h100);

        // redirect coincident with the returning read
        do_reset(0);
        drv_ready = 1; drv_gnt = 1; mem_lat = 2;
        wait_grant("rv_first");
        drv_target = 32'h200; pcsrc_on_rv = 1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (pcsrc) break;
        end
        pcsrc_on_rv = 0;
        cycle();
        check("rv_redirect_req", imem_req, 1);
        check("rv_redirect_addr", imem_addr, 32'h200);
        check("rv_dropped", instr_valid, 0);

        // stall with a request held until a late grant
        do_reset(0);
        drv_gnt = 0; drv_ready = 0; mem_lat = 0;
        cycle();
        cycle();
        check("stall_req0", imem_req, 1);
        drv_stall = 1;
        repeat (2) begin
            cycle();
            check("stall_hold_req", imem_req, 1);
            check("stall_hold_addr", imem_addr, 0);
        end
        drv_gnt = 1;
        cycle();
        check("stall_gnt", imem_req & imem_gnt, 1);
        cycle();
        repeat (4) begin
            cycle();
            check("stall_noreq", imem_req, 0);
        end
        check("stall_pushed", instr_valid, 1);
        check("stall_pushed_pc", instr_pc, 0);
        drv_stall = 0;
        cycle();
        check("unstall_req", imem_req, 1);
        check("unstall_addr", imem_addr, 32'h4);
        drv_ready = 1;

        // reset in the middle of a read, then a stray response
        do_reset(0);
        drv_gnt = 1; drv_ready = 1; mem_lat = 8;
        wait_grant("mid_first");
        drv_gnt = 0;
        cycle();
        do_reset(1);
        for (int i = 0; i < 20 && mem_busy; i++) begin
            cycle();
            check("stray_valid", instr_valid, 0);
        end
        repeat (3) begin
            cycle();
            check("stray_after", instr_valid, 0);
        end
        mem_lat = 0; drv_gnt = 1;
        wait_grant("post_reset");
        check("post_reset_addr", last_grant_addr, 0);

        // random traffic against the model
        do_reset(0);
        mem_lat = -1;
        p0 = pops;
        repeat (3000) begin
            drv_gnt   = ($urandom_range(0, 9) < 7);
            drv_ready = ($urandom_range(0, 9) < 7);
            drv_stall = ($urandom_range(0, 9) < 2);
            if ($urandom_range(0, 24) == 0) begin
                drv_pcsrc = 1;
                case ($urandom_range(0, 2))
                    0:       drv_target = $urandom;
                    1:       drv_target = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                    default: drv_target = 32'($urandom_range(0, 255));
                endcase
            end
            cycle();
        end
        check("random_progress", (pops - p0) > 150, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
